// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, single-step mode, lock-up guard,
// hardware period measurement and a seven-segment readout of the state.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         mode,
    input  logic                         step,
    input  logic                         load,
    input  logic [WIDTH-1:0]             seed_in,
    output logic [WIDTH-1:0]             state,
    output logic                         out_bit,
    output logic                         lockup,
    output logic [WIDTH-1:0]             period,
    output logic                         period_valid,
    output logic [7*((WIDTH+3)/4)-1:0]   hex
);

    localparam int unsigned      DIGITS    = (WIDTH + 3) / 4;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_INIT = (SEED == '0) ? ONE : SEED;

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             lockup_q, lockup_d;
    logic             step_q, step_d;

    logic             fb;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_val;
    logic             step_rise;
    logic             advance;

    assign fb         = ^(state_q & TAPS);
    assign next_state = {fb, state_q[WIDTH-1:1]};
    assign seed_val   = (seed_in == '0) ? ONE : seed_in;
    assign step_rise  = step & ~step_q;
    assign advance    = en & (~mode | step_rise) & ~load;

    always_comb begin
        state_d        = state_q;
        ref_d          = ref_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        lockup_d       = 1'b0;
        // The edge detector samples every cycle so a step during en==0 is consumed.
        step_d         = step;

        if (load) begin
            state_d        = seed_val;
            ref_d          = seed_val;
            cnt_d          = '0;
            period_valid_d = 1'b0;
            lockup_d       = (seed_in == '0);
        end else if (advance) begin
            state_d = next_state;
            if (next_state == ref_q) begin
                period_d       = cnt_q + ONE;
                period_valid_d = 1'b1;
                cnt_d          = '0;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= SEED_INIT;
            ref_q          <= SEED_INIT;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            lockup_q       <= 1'b0;
            step_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            lockup_q       <= lockup_d;
            step_q         <= step_d;
        end
    end

    assign state        = state_q;
    assign out_bit      = state_q[0];
    assign lockup       = lockup_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] state_pad;
    assign state_pad = (4 * DIGITS)'(state_q);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign hex[7*k +: 7] = seg7(state_pad[4*k +: 4]);
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: table-driven vectors through a scoreboard queue on the
// default 8-bit instance, full-period runs on 8-bit and 4-bit instances.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit default instance
    logic       rst, en, mode, step, load;
    logic [7:0] seed_in;
    logic [7:0] state, period;
    logic       out_bit, lockup, period_valid;
    logic [13:0] hex;

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step), .load(load),
        .seed_in(seed_in), .state(state), .out_bit(out_bit), .lockup(lockup),
        .period(period), .period_valid(period_valid), .hex(hex)
    );

    // 4-bit instance
    logic       rst4, en4, mode4, step4, load4;
    logic [3:0] seed4, state4, period4;
    logic       out_bit4, lockup4, period_valid4;
    logic [6:0] hex4;

    lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h1)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .step(step4), .load(load4),
        .seed_in(seed4), .state(state4), .out_bit(out_bit4), .lockup(lockup4),
        .period(period4), .period_valid(period_valid4), .hex(hex4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[d];
    endfunction

    // x^8+x^4+x^3+x^2+1 and x^4+x+1, written out independently of the mask.
    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    endfunction
    function automatic logic [3:0] nxt4(input logic [3:0] s);
        return {s[0] ^ s[1], s[3:1]};
    endfunction

    typedef struct {
        logic       rst, en, mode, step, load;
        logic [7:0] seed;
        logic [7:0] st;
        logic       lk;
    } vec_t;

    typedef struct {
        logic [7:0]  st;
        logic        lk, pv;
        logic [7:0]  per;
        logic [13:0] hx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic addv(input logic r, input logic e, input logic m, input logic s,
                        input logic l, input logic [7:0] sd, input logic [7:0] st,
                        input logic lk);
        vec_t v;
        v = '{rst: r, en: e, mode: m, step: s, load: l, seed: sd, st: st, lk: lk};
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [7:0] st, input logic lk, input logic pv,
                            input logic [7:0] per);
        exp_t x;
        x = '{st: st, lk: lk, pv: pv, per: per, hx: {seg(st[7:4]), seg(st[3:0])}};
        sb.push_back(x);
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        x = sb.pop_front();
        check({tag, " state"}, 32'(state), 32'(x.st));
        check({tag, " out_bit"}, 32'(out_bit), 32'(x.st[0]));
        check({tag, " lockup"}, 32'(lockup), 32'(x.lk));
        check({tag, " period_valid"}, 32'(period_valid), 32'(x.pv));
        check({tag, " period"}, 32'(period), 32'(x.per));
        check({tag, " hex"}, 32'(hex), 32'(x.hx));
    endtask

    initial begin
        logic [7:0]  m8;
        logic [3:0]  m4;
        logic [15:0] seen;

        rst = 0; en = 0; mode = 0; step = 0; load = 0; seed_in = '0;
        rst4 = 0; en4 = 0; mode4 = 0; step4 = 0; load4 = 0; seed4 = '0;

        //   rst en md st ld seed   state lk
        addv(0, 0, 0, 0, 0, 8'h00, 8'h01, 0);
        addv(0, 0, 0, 0, 0, 8'h00, 8'h01, 0);
        addv(1, 1, 0, 0, 0, 8'h00, 8'h80, 0);
        addv(1, 1, 0, 0, 0, 8'h00, 8'h40, 0);
        addv(1, 1, 0, 0, 0, 8'h00, 8'h20, 0);
        addv(1, 1, 0, 0, 0, 8'h00, 8'h10, 0);
        addv(1, 1, 0, 0, 0, 8'h00, 8'h88, 0);
        addv(1, 1, 1, 1, 0, 8'h00, 8'hC4, 0);   // first step edge
        for (int i = 0; i < 5; i++) addv(1, 1, 1, 1, 0, 8'h00, 8'hC4, 0);
        addv(1, 1, 1, 0, 0, 8'h00, 8'hC4, 0);
        addv(1, 1, 1, 1, 0, 8'h00, 8'hE2, 0);   // second step edge
        addv(1, 1, 1, 0, 0, 8'h00, 8'hE2, 0);
        addv(1, 0, 1, 1, 0, 8'h00, 8'hE2, 0);   // edge while en==0 is consumed
        addv(1, 1, 1, 1, 0, 8'h00, 8'hE2, 0);
        addv(1, 1, 1, 0, 1, 8'h00, 8'h01, 1);   // zero seed -> lockup
        addv(1, 0, 0, 0, 0, 8'h00, 8'h01, 0);
        addv(1, 1, 0, 0, 1, 8'hA5, 8'hA5, 0);   // load beats advance
        addv(1, 1, 0, 0, 0, 8'h00, 8'h52, 0);
        addv(1, 1, 1, 0, 0, 8'h00, 8'h52, 0);   // mode switch, no step
        addv(0, 1, 1, 1, 1, 8'h33, 8'h01, 0);   // reset beats load/step
        addv(1, 1, 1, 1, 0, 8'h00, 8'h80, 0);   // step held across release
        addv(1, 1, 1, 1, 0, 8'h00, 8'h80, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            step = vecs[i].step; load = vecs[i].load; seed_in = vecs[i].seed;
            push_exp(vecs[i].st, vecs[i].lk, 1'b0, 8'h00);
            @(posedge clk); #1;
            pop_check($sformatf("v%0d", i));
            if (i == 0) check("reset hex literal", 32'(hex), 32'h2079);
        end

        // Full-period free run from reset.
        rst = 0; en = 0; mode = 0; step = 0; load = 0;
        @(posedge clk); #1;
        rst = 1; en = 1;
        m8 = 8'h01;
        for (int c = 1; c <= 255; c++) begin
            m8 = nxt8(m8);
            push_exp(m8, 1'b0, (c == 255), (c == 255) ? 8'd255 : 8'd0);
            @(posedge clk); #1;
            pop_check($sformatf("run8 c%0d", c));
        end
        check("run8 returned to seed", 32'(state), 32'h01);
        for (int c = 0; c < 10; c++) begin
            m8 = nxt8(m8);
            push_exp(m8, 1'b0, 1'b1, 8'd255);
            @(posedge clk); #1;
            pop_check($sformatf("post8 c%0d", c));
        end
        load = 1; seed_in = 8'h5A;
        push_exp(8'h5A, 1'b0, 1'b0, 8'd255);
        @(posedge clk); #1;
        pop_check("load clears valid");
        load = 0; en = 0;

        // 4-bit instance: every nonzero state exactly once per period.
        @(posedge clk); #1;
        rst4 = 1; en4 = 1;
        m4 = 4'h1;
        seen = '0;
        for (int c = 1; c <= 15; c++) begin
            m4 = nxt4(m4);
            @(posedge clk); #1;
            check($sformatf("w4 c%0d state", c), 32'(state4), 32'(m4));
            check($sformatf("w4 c%0d hex", c), 32'(hex4), 32'(seg(m4)));
            check($sformatf("w4 c%0d unique", c), 32'(seen[state4]), 32'd0);
            check($sformatf("w4 c%0d valid", c), 32'(period_valid4), 32'(c == 15));
            seen[state4] = 1'b1;
        end
        check("w4 period", 32'(period4), 32'd15);
        check("w4 states visited", 32'($countones(seen)), 32'd15);
        check("w4 zero unvisited", 32'(seen[0]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
        end
        rst4 = 0; load4 = 1; seed4 = 4'h9;
        @(posedge clk); #1;
        check("w4 reset state", 32'(state4), 32'h1);
        check("w4 reset valid", 32'(period_valid4), 32'd0);
        check("w4 reset period", 32'(period4), 32'd0);
        check("w4 reset lockup", 32'(lockup4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
